// File: rtl/counter_7seg_pkg.sv
// counter_7seg_pkg: shared state encoding and widths for the 0-99 s seconds counter.
package counter_7seg_pkg;
    localparam int COUNT_W       = 7;
    localparam int MAX_COUNT_DEF = 99;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every CLK_HZ enabled cycles.
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);
    logic [PW-1:0] cnt;
    assign tick = en && cnt == LAST;
    // phase is held while en is low so a pause loses no fraction of a second
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (sync_clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sec_counter_99.sv
// sec_counter_99: start/stop/clear seconds counter feeding the 7-segment decoder.
// Define LAP_HOLD_EN to add the lap input and a display hold register.
module sec_counter_99
    import counter_7seg_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int MAX_COUNT = MAX_COUNT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_stop,
    input  logic               clear,
    input  logic               wrap_en,
`ifdef LAP_HOLD_EN
    input  logic               lap,
`endif
    output logic [COUNT_W-1:0] count,
    output logic               running,
    output logic               done,
    output logic               tc
);
    localparam logic [COUNT_W-1:0] MAXC = COUNT_W'(MAX_COUNT);
    state_t state, state_nx;
    logic [COUNT_W-1:0] cnt, cnt_nx;
    logic tick, run_nx, done_nx, tc_nx;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == RUN),
        .sync_clr (clear),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            tc      <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            running <= run_nx;
            done    <= done_nx;
            tc      <= tc_nx;
        end

    // clear beats tick, tick beats start_stop; reaching DONE swallows a same-cycle start_stop
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (clear) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else
            case (state)
                IDLE:  state_nx = start_stop ? RUN : IDLE;
                RUN: begin
                    if (tick) begin
                        cnt_nx = (cnt == MAXC) ? (wrap_en ? '0 : MAXC) : cnt + 1'b1;
                        if (!wrap_en && cnt_nx == MAXC)
                            state_nx = DONE;
                    end
                    if (start_stop && state_nx == RUN)
                        state_nx = PAUSE;
                end
                PAUSE: state_nx = start_stop ? RUN : PAUSE;
                default: state_nx = DONE;
            endcase
    end

    always_comb begin
        run_nx  = state_nx == RUN;
        done_nx = state_nx == DONE;
        tc_nx   = cnt_nx == MAXC && cnt != MAXC;
    end

`ifdef LAP_HOLD_EN
    logic hold, hold_nx;
    logic [COUNT_W-1:0] lap_cnt;
    assign hold_nx = !clear && (hold ^ lap);
    // while holding, the display register keeps the value shown when lap arrived
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold    <= 1'b0;
            lap_cnt <= '0;
        end else begin
            hold    <= hold_nx;
            lap_cnt <= hold_nx ? lap_cnt : cnt_nx;
        end
    assign count = lap_cnt;
`else
    assign count = cnt;
`endif
endmodule

// File: tb/tb_sec_counter_99.sv
// tb_sec_counter_99: directed and random stimulus against an elapsed-time reference model.
module tb_sec_counter_99;
    localparam int HZ = 4;
    localparam int MAXC = 5;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic clk = 1'b0, rst_n = 1'b1, start_stop = 1'b0, clear = 1'b0, wrap_en = 1'b0;
`ifdef LAP_HOLD_EN
    logic lap = 1'b0;
`endif
    logic [6:0] count;
    logic running, done, tc;
    int n_checks = 0, n_errors = 0;
    int m_st, m_rc, m_cnt, m_disp;
    bit m_tc, m_hold;

    always #5 clk = ~clk;

    sec_counter_99 #(.CLK_HZ(HZ), .MAX_COUNT(MAXC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
        .wrap_en    (wrap_en),
`ifdef LAP_HOLD_EN
        .lap        (lap),
`endif
        .count      (count),
        .running    (running),
        .done       (done),
        .tc         (tc)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE;
        m_rc = 0;
        m_cnt = 0;
        m_disp = 0;
        m_tc = 0;
        m_hold = 0;
    endtask

    // seconds = whole run-time periods elapsed since clear; wrap_en only changes alongside clear
    task automatic model_step(input bit ss, input bit cl, input bit lp);
        int prev = m_cnt;
        if (cl) begin
            m_st = S_IDLE;
            m_rc = 0;
            m_cnt = 0;
            m_hold = 0;
        end else begin
            if (m_st == S_RUN) begin
                m_rc++;
                if (!wrap_en && m_rc / HZ >= MAXC) begin
                    m_cnt = MAXC;
                    m_st = S_DONE;
                end else
                    m_cnt = (m_rc / HZ) % (MAXC + 1);
            end
            if (ss && m_st != S_DONE)
                m_st = (m_st == S_RUN) ? S_PAUSE : S_RUN;
            m_hold = m_hold ^ lp;
        end
        m_tc = (m_cnt == MAXC) && (prev != MAXC);
`ifdef LAP_HOLD_EN
        m_disp = m_hold ? m_disp : m_cnt;
`else
        m_disp = m_cnt;
`endif
    endtask

    task automatic cycle(input bit ss, input bit cl, input bit lp);
        start_stop = ss;
        clear = cl;
`ifdef LAP_HOLD_EN
        lap = lp;
`endif
        @(posedge clk);
        model_step(ss, cl, lp);
        #1;
        start_stop = 1'b0;
        clear = 1'b0;
`ifdef LAP_HOLD_EN
        lap = 1'b0;
`endif
        check("count", count, m_disp);
        check("running", running, int'(m_st == S_RUN));
        check("done", done, int'(m_st == S_DONE));
        check("tc", tc, int'(m_tc));
    endtask

    task automatic run(input int n);
        repeat (n) cycle(0, 0, 0);
    endtask

    initial begin
        bit cl, ss, lp;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_tc", tc, 0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_count", count, 0);
        check("idle_running", running, 0);

        wrap_en = 1'b0;
        cycle(1, 0, 0);
        check("start_running", running, 1);
        run(4);
        check("basic_cnt1", count, 1);
        run(4);
        check("basic_cnt2", count, 2);
        run(12);
        check("basic_cnt5", count, 5);
        check("basic_tc", tc, 1);
        check("basic_done", done, 1);
        check("basic_stopped", running, 0);
        run(1);
        check("tc_one_cycle", tc, 0);
        cycle(1, 0, 0);
        check("done_ignores_ss", done, 1);
        check("done_holds", count, 5);

        cycle(0, 1, 0);
        check("clear_count", count, 0);
        check("clear_done", done, 0);
        cycle(1, 0, 0);
        run(4);
        check("pr_cnt1", count, 1);
        run(1);
        cycle(1, 0, 0);
        check("pr_paused", running, 0);
        run(10);
        check("pr_frozen", count, 1);
        cycle(1, 0, 0);
        run(1);
        check("pr_not_yet", count, 1);
        run(1);
        check("pr_inc", count, 2);

        wrap_en = 1'b1;
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        run(20);
        check("wrap_cnt5", count, 5);
        check("wrap_tc", tc, 1);
        run(4);
        check("wrap_cnt0", count, 0);
        check("wrap_no_tc", tc, 0);
        check("wrap_running", running, 1);

        run(3);
        cycle(1, 1, 0);
        check("coll_clear_cnt", count, 0);
        check("coll_clear_idle", running, 0);
        cycle(1, 0, 0);
        run(3);
        cycle(1, 0, 0);
        check("coll_tick_ss_cnt", count, 1);
        check("coll_tick_ss_pause", running, 0);

        cycle(1, 0, 0);
        run(2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_count", count, 0);
        check("midrst_running", running, 0);
        check("midrst_done", done, 0);
        check("midrst_tc", tc, 0);
        #2 rst_n = 1'b1;
        cycle(0, 0, 0);

`ifdef LAP_HOLD_EN
        wrap_en = 1'b0;
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        run(8);
        cycle(0, 0, 1);
        run(7);
        check("lap_held4", count, 2);
        run(4);
        check("lap_tc", tc, 1);
        check("lap_held5", count, 2);
        cycle(0, 0, 1);
        check("lap_release", count, 5);
`endif

        cycle(0, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            cl = $urandom_range(0, 39) == 0;
            ss = $urandom_range(0, 9) == 0;
            lp = $urandom_range(0, 11) == 0;
            if (cl)
                wrap_en = 1'($urandom_range(0, 1));
            cycle(ss, cl, lp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sec_counter_99.md
# sec_counter_99

Seconds counter for the 0–99 s seven-segment counter. Divides the board clock down to a 1 Hz tick, counts seconds under start/stop/clear control, and drives the 7-bit unsigned `count` bus into the combinational binary-to-BCD/seven-segment decoder. It is the only sequential stage in front of the display path. It also exposes run status and a terminal-count pulse.

## Interface

Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency; tick period is `CLK_HZ` cycles; must be ≥ 2.
- `MAX_COUNT`, 99, terminal value; legal range 1–99 (fits the 7-bit decoder input).

Ports (one clock; reset is asynchronous and active-low):
- `clk`, input, 1, system clock; all state updates on its rising edge.
- `rst_n`, input, 1, asynchronous active-low reset.
- `start_stop`, input, 1, single-cycle pulse, already synchronized and debounced; toggles run/pause.
- `clear`, input, 1, single-cycle pulse; returns the block to IDLE.
- `wrap_en`, input, 1, level; 1 means wrap MAX_COUNT→0, 0 means stop at MAX_COUNT.
- `lap`, input, 1, single-cycle pulse; only present with `LAP_HOLD_EN`.
- `count`, output, 7, seconds value for the decoder; registered.
- `running`, output, 1, high in RUN.
- `done`, output, 1, high in DONE.
- `tc`, output, 1, one-cycle pulse when the internal count becomes MAX_COUNT.

## Operation

- States: IDLE, RUN, PAUSE, DONE. A 2-bit encoding is defined in the package.
- IDLE: count = 0, prescaler = 0. `start_stop` → RUN.
- RUN: prescaler counts 0..CLK_HZ−1 and `tick` fires at CLK_HZ−1. On `tick`, count increments.
  - `start_stop` → PAUSE.
  - If count == MAX_COUNT and `tick` and `wrap_en`=1: count → 0, stay RUN.
  - If an increment makes count == MAX_COUNT and `wrap_en`=0: → DONE.
- PAUSE: prescaler and count frozen. `start_stop` → RUN, and the prescaler resumes from its held value (no lost fraction).
- DONE: count held at MAX_COUNT. `start_stop` is ignored.
- `clear` in any state: → IDLE, count = 0, prescaler = 0.
- Priority in the same cycle: `clear` > `tick` > `start_stop`. In RUN, a simultaneous `tick` and `start_stop` applies the increment, then enters PAUSE.
- `tc` fires on entry to MAX_COUNT in both wrap modes. A wrap to 0 does not pulse `tc`.
- Arithmetic: count is 7-bit unsigned and never exceeds MAX_COUNT. The prescaler width is $clog2(CLK_HZ).

## Timing

- Reset values: count = 0, running = 0, done = 0, tc = 0, state IDLE, prescaler 0. Reset applies immediately on `rst_n` low and is released synchronously at the first edge with `rst_n` high.
- `start_stop` sampled at edge n → `running` = 1 after edge n. The first increment occurs at edge n + CLK_HZ.
- `count`, `running`, `done` and `tc` are all registered and change on the same edge as the state change. No combinational path exists from inputs to outputs.
- `tc` is high for exactly one cycle following the edge where count becomes MAX_COUNT.
- `clear` takes effect at the next edge and resets the prescaler phase.

## Configuration

`LAP_HOLD_EN` adds the `lap` port and a 7-bit lap register.
- With the macro: `lap` toggles hold mode. In hold, `count` shows the value captured at the `lap` edge while the internal count keeps running. A second `lap` releases the hold, and `count` tracks live again from the next edge. `clear` also releases the hold. `tc`, `running` and `done` always reflect the internal count.
- Without the macro: there is no port and no register, and `count` is always the live value.

## Structure

- Package `counter_7seg_pkg`: state enum (IDLE, RUN, PAUSE, DONE), `COUNT_W` = 7, default MAX_COUNT constant.
- Sub-module `tick_prescaler`:
  - Parameter `CLK_HZ`.
  - Inputs `clk`, `rst_n`, `en`, `sync_clr`.
  - Output `tick`, a one-cycle pulse.
- The FSM, the count register and the optional lap register live in `sec_counter_99`.

## Test plan

The bench uses CLK_HZ = 4 and MAX_COUNT = 5.

- Reset → after release: count 0, running 0, done 0, tc 0. Assert `rst_n` low mid-RUN → all outputs return to reset values immediately.
- Basic run: `start_stop` pulse → running 1; count 1 after 4 cycles, 2 after 8; with `wrap_en`=0, count 5 after 20 cycles, tc one-cycle pulse, done 1, running 0.
- Pause/resume: pause 2 cycles after the first increment, wait 10 cycles, resume → the next increment arrives exactly 2 cycles after resume (prescaler phase kept).
- Wrap: `wrap_en`=1, run → tc at the 5 entry; count 0 on the next tick; stays RUN; no tc at the wrap.
- Collisions: `clear` together with `tick` and `start_stop` → IDLE, count 0. `start_stop` together with `tick` in RUN → count increments, state PAUSE. `start_stop` in DONE → no change.
- `LAP_HOLD_EN`: `lap` at count 2 → `count` stays 2 while the internal count reaches 4 (tc fires at 5). Second `lap` → `count` shows the live value on the next edge.
